// File: rtl/pcie_tl_pkg.sv
// rtl/pcie_tl_pkg.sv - shared state encodings and default sizes for the TL FIFO-bank controller
package pcie_tl_pkg;

    localparam int STATE_W    = 5;
    localparam int DEF_NUM_CH = 8;
    localparam int DEF_OCC_W  = 3;

    // One-hot so downstream logic can decode a state with a single bit test.
    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

endpackage

// File: rtl/pcie_tl_ctrl_fsm_thr_cmp.sv
// rtl/pcie_tl_ctrl_fsm_thr_cmp.sv - single-channel occupancy vs threshold comparator
module pcie_tl_thr_cmp #(
    parameter int OCC_W = 3
) (
    input  logic [OCC_W-1:0] occ,
    input  logic [OCC_W-1:0] thr_hi,
    input  logic [OCC_W-1:0] thr_lo,
    output logic             almost_full,
    output logic             almost_empty
);

    // Unsigned compares; the controller registers these results.
    assign almost_full  = (occ >= thr_hi);
    assign almost_empty = (occ <= thr_lo);

endmodule

// File: rtl/pcie_tl_ctrl_fsm.sv
// rtl/pcie_tl_ctrl_fsm.sv - control FSM, threshold latch and registered occupancy flags for the TL FIFO bank
module pcie_tl_ctrl_fsm
    import pcie_tl_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int OCC_W  = DEF_OCC_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [OCC_W-1:0]        thr_hi_in,
    input  logic [OCC_W-1:0]        thr_lo_in,
    input  logic [NUM_CH-1:0]       empty,
    input  logic [NUM_CH*OCC_W-1:0] occ,
    input  logic [NUM_CH-1:0]       err_in,
    output logic [STATE_W-1:0]      state,
    output logic [OCC_W-1:0]        thr_hi,
    output logic [OCC_W-1:0]        thr_lo,
    output logic [NUM_CH-1:0]       almost_full,
    output logic [NUM_CH-1:0]       almost_empty,
    output logic                    pause,
    output logic [NUM_CH-1:0]       err_ch,
    output logic                    cfg_err
);

    state_t              state_q, state_d;
    logic [OCC_W-1:0]    thr_hi_q, thr_hi_d;
    logic [OCC_W-1:0]    thr_lo_q, thr_lo_d;
    logic [NUM_CH-1:0]   af_q, af_d;
    logic [NUM_CH-1:0]   ae_q, ae_d;
    logic                pause_q;
    logic [NUM_CH-1:0]   err_ch_q, err_ch_d;
    logic                cfg_err_q, cfg_err_d;
    logic [NUM_CH-1:0]   cmp_af;
    logic [NUM_CH-1:0]   cmp_ae;

    // Compare each channel against the latched thresholds.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_cmp
        pcie_tl_thr_cmp #(
            .OCC_W (OCC_W)
        ) u_cmp (
            .occ          (occ[i*OCC_W +: OCC_W]),
            .thr_hi       (thr_hi_q),
            .thr_lo       (thr_lo_q),
            .almost_full  (cmp_af[i]),
            .almost_empty (cmp_ae[i])
        );
    end

    // Next-state, threshold, flag and sticky-error logic; init overrides everything but reset.
    always_comb begin
        state_d   = state_q;
        thr_hi_d  = thr_hi_q;
        thr_lo_d  = thr_lo_q;
        af_d      = '0;
        ae_d      = '0;
        err_ch_d  = err_ch_q;
        cfg_err_d = cfg_err_q;
        if (init) begin
            state_d   = ST_INIT;
            thr_hi_d  = thr_hi_in;
            thr_lo_d  = thr_lo_in;
            err_ch_d  = '0;
            cfg_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    state_d = ST_INIT;
                end
                ST_INIT: begin
                    if (thr_lo_q <= thr_hi_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_ERROR;
                        cfg_err_d = 1'b1;
                    end
                end
                ST_IDLE: begin
                    err_ch_d = err_ch_q | err_in;
                    if (|err_in) begin
                        state_d = ST_ERROR;
                    end else begin
                        af_d = cmp_af;
                        ae_d = cmp_ae;
                        if (~&empty) begin
                            state_d = ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    err_ch_d = err_ch_q | err_in;
                    if (|err_in) begin
                        state_d = ST_ERROR;
                    end else begin
                        af_d = cmp_af;
                        ae_d = cmp_ae;
                        if (&empty) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_ERROR: begin
                    err_ch_d = err_ch_q | err_in;
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
    end

    // State and output registers; pause derives from the same next-values as almost_full.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RESET;
            thr_hi_q  <= '0;
            thr_lo_q  <= '0;
            af_q      <= '0;
            ae_q      <= '0;
            pause_q   <= 1'b0;
            err_ch_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            thr_hi_q  <= thr_hi_d;
            thr_lo_q  <= thr_lo_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            pause_q   <= |af_d;
            err_ch_q  <= err_ch_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign state        = state_q;
    assign thr_hi       = thr_hi_q;
    assign thr_lo       = thr_lo_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign pause        = pause_q;
    assign err_ch       = err_ch_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_pcie_tl_ctrl_fsm.sv
// tb/tb_pcie_tl_ctrl_fsm.sv - self-checking bench for pcie_tl_ctrl_fsm against a cycle-level behavioural model
module tb_pcie_tl_ctrl_fsm;

    localparam int NC    = 8;
    localparam int OW    = 3;
    localparam int BUS_W = 5 + 2*OW + 3*NC + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance, tracked by the model.
    logic              reset, init;
    logic [OW-1:0]     thr_hi_in, thr_lo_in;
    logic [NC-1:0]     empty, err_in;
    logic [NC*OW-1:0]  occ;
    logic [4:0]        state;
    logic [OW-1:0]     thr_hi, thr_lo;
    logic [NC-1:0]     almost_full, almost_empty, err_ch;
    logic              pause, cfg_err;

    pcie_tl_ctrl_fsm u_dut (
        .clk(clk), .reset(reset), .init(init),
        .thr_hi_in(thr_hi_in), .thr_lo_in(thr_lo_in),
        .empty(empty), .occ(occ), .err_in(err_in),
        .state(state), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .pause(pause), .err_ch(err_ch), .cfg_err(cfg_err)
    );

    // NUM_CH=4, OCC_W=5 instance for the wide-threshold boundaries.
    logic        reset_b, init_b;
    logic [4:0]  thr_hi_in_b, thr_lo_in_b;
    logic [3:0]  empty_b, err_in_b;
    logic [19:0] occ_b;
    logic [4:0]  state_b;
    logic [4:0]  thr_hi_b, thr_lo_b;
    logic [3:0]  almost_full_b, almost_empty_b, err_ch_b;
    logic        pause_b, cfg_err_b;

    pcie_tl_ctrl_fsm #(.NUM_CH(4), .OCC_W(5)) u_dut_b (
        .clk(clk), .reset(reset_b), .init(init_b),
        .thr_hi_in(thr_hi_in_b), .thr_lo_in(thr_lo_in_b),
        .empty(empty_b), .occ(occ_b), .err_in(err_in_b),
        .state(state_b), .thr_hi(thr_hi_b), .thr_lo(thr_lo_b),
        .almost_full(almost_full_b), .almost_empty(almost_empty_b),
        .pause(pause_b), .err_ch(err_ch_b), .cfg_err(cfg_err_b)
    );

    // Model: m_st is a phase index 0=RESET 1=INIT 2=IDLE 3=ACTIVE 4=ERROR.
    int            m_st;
    int            m_hi, m_lo;
    logic [NC-1:0] m_af, m_ae, m_err;
    logic          m_cfg;

    int errors = 0;
    int checks = 0;

    logic [BUS_W-1:0] dut_bus;
    assign dut_bus = {state, thr_hi, thr_lo, almost_full, almost_empty, pause, err_ch, cfg_err};

    function automatic logic [BUS_W-1:0] exp_bus();
        return {5'(1 << m_st), OW'(m_hi), OW'(m_lo), m_af, m_ae, |m_af, m_err, m_cfg};
    endfunction

    // One clock: the model consumes the inputs present at the edge, outputs are sampled 1 ns later.
    task automatic step();
        int c;
        @(posedge clk);
        if (reset) begin
            m_st = 0; m_hi = 0; m_lo = 0; m_af = '0; m_ae = '0; m_err = '0; m_cfg = 1'b0;
        end else if (init) begin
            m_st = 1; m_hi = int'(thr_hi_in); m_lo = int'(thr_lo_in);
            m_af = '0; m_ae = '0; m_err = '0; m_cfg = 1'b0;
        end else begin
            case (m_st)
                0: begin m_st = 1; m_af = '0; m_ae = '0; end
                1: begin
                    m_af = '0; m_ae = '0;
                    if (m_lo > m_hi) begin m_st = 4; m_cfg = 1'b1; end
                    else m_st = 2;
                end
                2, 3: begin
                    m_err = m_err | err_in;
                    if (err_in != '0) begin
                        m_st = 4; m_af = '0; m_ae = '0;
                    end else begin
                        for (int ch = 0; ch < NC; ch++) begin
                            c = int'(occ[ch*OW +: OW]);
                            m_af[ch] = (c >= m_hi);
                            m_ae[ch] = (c <= m_lo);
                        end
                        if (m_st == 2 && empty != {NC{1'b1}}) m_st = 3;
                        else if (m_st == 3 && empty == {NC{1'b1}}) m_st = 2;
                    end
                end
                default: begin m_err = m_err | err_in; m_af = '0; m_ae = '0; end
            endcase
        end
        #1;
    endtask

    task automatic set_occ(input int ch, input int val);
        occ[ch*OW +: OW] = OW'(val);
    endtask

    // Bring the default instance from any state to ACTIVE with thresholds 6/1.
    task automatic goto_active();
        reset = 0; err_in = '0; empty = '1; occ = '0;
        init = 1; thr_hi_in = 3'd6; thr_lo_in = 3'd1; step();
        init = 0; step();
        empty = 8'hFE; set_occ(0, 3); step();
    endtask

    task automatic test_reset();
        reset = 1; init = 0; thr_hi_in = '0; thr_lo_in = '0; empty = '1; occ = '0; err_in = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dut_bus !== exp_bus()) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got %h want %h", i, dut_bus, exp_bus());
            end
        end
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dut_bus !== exp_bus()) begin
                errors++;
                $display("FAIL reset_release cyc%0d: got %h want %h", i, dut_bus, exp_bus());
            end
        end
        checks++;
        if (state !== 5'b00100 || thr_hi !== 3'd0 || thr_lo !== 3'd0) begin
            errors++;
            $display("FAIL reset_to_idle: got state=%b hi=%0d lo=%0d want 00100/0/0", state, thr_hi, thr_lo);
        end
    endtask

    task automatic test_basic();
        init = 1; thr_hi_in = 3'd6; thr_lo_in = 3'd1; empty = '1; occ = '0; step();
        checks++;
        if (dut_bus !== exp_bus() || state !== 5'b00010) begin
            errors++;
            $display("FAIL basic_init: got %h want %h", dut_bus, exp_bus());
        end
        init = 0; step();
        checks++;
        if (dut_bus !== exp_bus() || thr_hi !== 3'd6 || thr_lo !== 3'd1) begin
            errors++;
            $display("FAIL basic_idle: got %h want %h", dut_bus, exp_bus());
        end
        set_occ(2, 6); empty = 8'hFB; step();
        checks++;
        if (dut_bus !== exp_bus() || almost_full !== 8'h04 || almost_empty !== 8'hFB
            || pause !== 1'b1 || state !== 5'b01000) begin
            errors++;
            $display("FAIL basic_active: got %h want %h", dut_bus, exp_bus());
        end
        empty = '1; occ = '0; step();
        checks++;
        if (dut_bus !== exp_bus() || state !== 5'b00100) begin
            errors++;
            $display("FAIL basic_back_idle: got %h want %h", dut_bus, exp_bus());
        end
    endtask

    task automatic test_error();
        goto_active();
        err_in = 8'h20; step();
        checks++;
        if (dut_bus !== exp_bus() || err_ch !== 8'h20 || state !== 5'b10000 || almost_full !== 8'h00) begin
            errors++;
            $display("FAIL err_entry: got %h want %h", dut_bus, exp_bus());
        end
        err_in = 8'h01; step();
        err_in = '0; step();
        checks++;
        if (dut_bus !== exp_bus() || err_ch !== 8'h21 || state !== 5'b10000) begin
            errors++;
            $display("FAIL err_sticky: got %h want %h", dut_bus, exp_bus());
        end
        init = 1; step();
        checks++;
        if (dut_bus !== exp_bus() || err_ch !== 8'h00) begin
            errors++;
            $display("FAIL err_clear_by_init: got %h want %h", dut_bus, exp_bus());
        end
        init = 0; step();
        checks++;
        if (dut_bus !== exp_bus() || state !== 5'b00100) begin
            errors++;
            $display("FAIL err_recover_idle: got %h want %h", dut_bus, exp_bus());
        end
    endtask

    task automatic test_cfg_err();
        init = 1; thr_hi_in = 3'd2; thr_lo_in = 3'd5; step();
        init = 0; step();
        checks++;
        if (dut_bus !== exp_bus() || cfg_err !== 1'b1 || state !== 5'b10000) begin
            errors++;
            $display("FAIL cfg_err_set: got %h want %h", dut_bus, exp_bus());
        end
        init = 1; thr_hi_in = 3'd5; thr_lo_in = 3'd2; step();
        init = 0; step();
        checks++;
        if (dut_bus !== exp_bus() || cfg_err !== 1'b0 || state !== 5'b00100) begin
            errors++;
            $display("FAIL cfg_err_clear: got %h want %h", dut_bus, exp_bus());
        end
    endtask

    task automatic test_priority();
        goto_active();
        init = 1; err_in = 8'hFF; step();
        checks++;
        if (dut_bus !== exp_bus() || err_ch !== 8'h00 || state !== 5'b00010) begin
            errors++;
            $display("FAIL init_beats_err: got %h want %h", dut_bus, exp_bus());
        end
        init = 0; err_in = '0;
        goto_active();
        set_occ(5, 7); reset = 1; step();
        checks++;
        if (dut_bus !== exp_bus() || dut_bus !== {5'b00001, {(BUS_W-5){1'b0}}}) begin
            errors++;
            $display("FAIL reset_in_active: got %h want %h", dut_bus, exp_bus());
        end
        reset = 0; occ = '0;
    endtask

    task automatic test_boundary();
        // thr_hi=0 and thr_lo=max (lo>hi, so go through equal thresholds for the flag cases).
        init = 1; thr_hi_in = 3'd0; thr_lo_in = 3'd0; empty = '1; occ = '1; step();
        init = 0; step(); step();
        checks++;
        if (dut_bus !== exp_bus() || almost_full !== 8'hFF || state !== 5'b00100) begin
            errors++;
            $display("FAIL thr_hi_zero: got %h want %h", dut_bus, exp_bus());
        end
        init = 1; thr_hi_in = 3'd7; thr_lo_in = 3'd7; occ = '0; step();
        init = 0; step(); step();
        checks++;
        if (dut_bus !== exp_bus() || almost_empty !== 8'hFF || almost_full !== 8'h00) begin
            errors++;
            $display("FAIL thr_lo_max: got %h want %h", dut_bus, exp_bus());
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r      = int'($urandom_range(0, 99));
            reset  = (r < 2);
            init   = (r >= 2 && r < 8);
            thr_hi_in = 3'($urandom);
            thr_lo_in = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, int'(thr_hi_in)));
            occ    = 24'($urandom);
            empty  = ($urandom_range(0, 2) == 0) ? '1 : 8'($urandom);
            err_in = ($urandom_range(0, 15) == 0) ? 8'(1 << $urandom_range(0, 7)) : '0;
            step();
            checks++;
            if (dut_bus !== exp_bus()) begin
                errors++;
                $display("FAIL random cyc%0d: got %h want %h", i, dut_bus, exp_bus());
            end
        end
        reset = 0; init = 0; err_in = '0;
    endtask

    task automatic test_param_wide();
        reset_b = 1; init_b = 0; thr_hi_in_b = '0; thr_lo_in_b = '0;
        empty_b = '1; occ_b = '0; err_in_b = '0;
        step();
        reset_b = 0; init_b = 1; thr_hi_in_b = 5'd31; thr_lo_in_b = 5'd0; step();
        init_b = 0; step();
        occ_b[15 +: 5] = 5'd31; empty_b = 4'b0111; step();
        checks++;
        if (almost_full_b !== 4'h8 || almost_empty_b !== 4'h7 || pause_b !== 1'b1 || state_b !== 5'b01000) begin
            errors++;
            $display("FAIL wide_thr31: got af=%h ae=%h st=%b want 8/7/01000", almost_full_b, almost_empty_b, state_b);
        end
        init_b = 1; thr_hi_in_b = 5'd0; thr_lo_in_b = 5'd0; empty_b = '1; step();
        init_b = 0; step(); step();
        checks++;
        if (almost_full_b !== 4'hF || state_b !== 5'b00100 || thr_hi_b !== 5'd0) begin
            errors++;
            $display("FAIL wide_thr0: got af=%h st=%b hi=%0d want F/00100/0", almost_full_b, state_b, thr_hi_b);
        end
    endtask

    initial begin
        reset_b = 1; init_b = 0; thr_hi_in_b = '0; thr_lo_in_b = '0;
        empty_b = '1; occ_b = '0; err_in_b = '0;
        m_st = 0; m_hi = 0; m_lo = 0; m_af = '0; m_ae = '0; m_err = '0; m_cfg = 1'b0;
        test_reset();
        test_basic();
        test_error();
        test_cfg_err();
        test_priority();
        test_boundary();
        test_random();
        test_param_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcie_tl_ctrl_fsm.md
Name: pcie_tl_ctrl_fsm

Overview:
Parametrised control state machine for the transaction-layer FIFO bank. It sequences RESET/INIT/IDLE/ACTIVE across NUM_CH virtual-channel FIFOs and latches the high/low occupancy thresholds at init. It generates registered per-channel almost-full/almost-empty flags from FIFO occupancy and adds a sticky ERROR state for FIFO overflow/underflow and bad threshold configuration. It sits beside the FIFO bank and feeds the arbiter and flow-control logic.

Parameters:
NUM_CH, 8, number of channels/FIFOs monitored
OCC_W, 3, width of each occupancy count and of each threshold

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
init  input  1  load thresholds and enter INIT (one-cycle pulse or level)
thr_hi_in  input  OCC_W  high (almost-full) threshold, sampled when init=1
thr_lo_in  input  OCC_W  low (almost-empty) threshold, sampled when init=1
empty  input  NUM_CH  per-channel FIFO empty flags
occ  input  NUM_CH*OCC_W  flattened occupancies; channel i at [i*OCC_W +: OCC_W]
err_in  input  NUM_CH  per-channel overflow/underflow pulses from the FIFOs
state  output  5  registered one-hot state
thr_hi  output  OCC_W  latched high threshold
thr_lo  output  OCC_W  latched low threshold
almost_full  output  NUM_CH  registered, occ[i] >= thr_hi
almost_empty  output  NUM_CH  registered, occ[i] <= thr_lo
pause  output  1  registered OR of almost_full
err_ch  output  NUM_CH  sticky record of channels that raised err_in
cfg_err  output  1  sticky, latched thr_lo > thr_hi

Behaviour:
- Reset is synchronous, active-high on clk. On reset all outputs are 0 except state=RESET.
- State encodings (shared constants): RESET=5'b00001, INIT=5'b00010, IDLE=5'b00100, ACTIVE=5'b01000, ERROR=5'b10000. state is a flop, not a combinational alias.
- Priority per cycle: reset > init > error entry > normal transition.
- init=1 (any state, including ERROR):
  - next state = INIT; thr_hi<=thr_hi_in; thr_lo<=thr_lo_in.
  - err_ch, cfg_err, almost_* and pause are cleared.
  - init held high keeps the block in INIT and re-samples the thresholds every cycle.
- RESET -> INIT unconditionally on the next cycle. Thresholds stay 0 until init is seen.
- INIT -> IDLE if thr_lo <= thr_hi (latched values). Otherwise -> ERROR with cfg_err<=1.
- IDLE:
  - any err_in -> ERROR;
  - else if any empty[i]==0 -> ACTIVE;
  - else stay.
- ACTIVE:
  - any err_in -> ERROR;
  - else if all empty==1 -> IDLE;
  - else stay.
- ERROR: stays until reset or init. err_ch |= err_in is accumulated in IDLE, ACTIVE and ERROR; the triggering bits are captured in the same edge as the transition.
- Flags:
  - almost_full/almost_empty are updated every cycle while the state register is IDLE or ACTIVE, with 1-cycle latency from occ.
  - They are forced to 0 in RESET, INIT and ERROR.
  - pause = |almost_full computed from the same next-values, so it is aligned with almost_full.
- Comparisons are unsigned on OCC_W bits.
  - thr_hi=0 makes almost_full always 1.
  - thr_lo = 2^OCC_W-1 makes almost_empty always 1.
  - thr_lo==thr_hi is legal.
- No combinational path from any input to any output.

Decomposition:
- Package pcie_tl_pkg: the five state constants, STATE_W=5, default NUM_CH/OCC_W.
- One sub-module, pcie_tl_thr_cmp (single channel: occ, thr_hi, thr_lo -> almost_full, almost_empty, combinational). It is instantiated NUM_CH times in a generate loop, and the FSM registers its outputs.

Test Plan:
1. Reset 3 cycles, release, init=0 -> state RESET then INIT then IDLE; thr_hi=thr_lo=0; flags 0.
2. init pulse with thr_hi_in=6, thr_lo_in=1, all empty -> INIT, IDLE; thr_hi=6, thr_lo=1. Then occ[2]=6, empty[2]=0 -> next cycle ACTIVE; one cycle after occ changes, almost_full=8'h04, pause=1, almost_empty=8'hFB. Then empty all 1, occ 0 -> back to IDLE.
3. In ACTIVE, err_in=8'h20 for one cycle -> next state ERROR, err_ch=8'h20, flags 0. Then err_in=8'h01 -> err_ch=8'h21. Then init -> INIT, err_ch=0, then IDLE.
4. init with thr_lo_in=5, thr_hi_in=2 -> INIT then ERROR, cfg_err=1. Re-init with 2/5 -> IDLE, cfg_err=0.
5. Same cycle: init=1 and err_in=8'hFF in ACTIVE -> INIT wins, err_ch=0. Then reset asserted in ACTIVE with occ non-zero -> next cycle RESET, all flags 0, thresholds 0.
6. NUM_CH=4, OCC_W=5 build: thr_hi=31, occ[3]=31 -> almost_full=4'h8. Boundary thr_hi=0 -> almost_full all 1 in IDLE.
